// File: rtl/rr_priority_encoder.sv
// Registered N-to-log2(N) priority encoder with valid/ready handshake.
//
// An accepted request vector produces, one cycle later, the index of the
// winning bit plus zero (no bit set) and multi (two or more bits set) flags.
// Fixed mode picks the highest set bit. Round-robin mode searches upward from
// a rotating pointer, wrapping at N-1, and advances the pointer past the
// winner on every non-zero accept.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - synchronous active-high reset
//   in_valid  - req carries a valid request vector
//   in_ready  - block can accept req this cycle (combinational from out_ready)
//   req       - N-bit request vector
//   out_valid - idx/zero/multi hold a valid result
//   out_ready - consumer takes the result this cycle
//   idx       - index of the winning request
//   zero      - accepted vector was all zeros
//   multi     - accepted vector had more than one bit set
module rr_priority_encoder #(
  parameter int unsigned N       = 8,
  parameter int unsigned RR_MODE = 0,
  localparam int unsigned W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] idx,
  output logic         zero,
  output logic         multi
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic         zero_q, zero_d;
  logic         multi_q, multi_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic         req_zero;
  logic         req_multi;
  logic [W-1:0] fixed_idx;
  logic [W-1:0] rr_hi_idx;   // lowest set bit at or above ptr
  logic         rr_hi_found;
  logic [W-1:0] rr_lo_idx;   // lowest set bit overall, used when the search wraps
  logic [W-1:0] win_idx;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign req_zero  = (req == '0);
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign req_multi = ((req & (req - N'(1))) != '0);

  // Winner search. Scanning downward lets the last hit be the lowest index,
  // and the first hit (overwritten by later ones) the highest.
  always_comb begin
    fixed_idx   = '0;
    rr_hi_idx   = '0;
    rr_hi_found = 1'b0;
    rr_lo_idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (fixed_idx == '0 && !(i == 0 && req_multi)) begin
          if (fixed_idx == '0) fixed_idx = W'(i);
        end
        rr_lo_idx = W'(i);
        if (i >= int'(ptr_q)) begin
          rr_hi_idx   = W'(i);
          rr_hi_found = 1'b1;
        end
      end
    end
    // fixed_idx above only records the first (highest) hit; a zero index
    // stays correct because bit 0 alone yields index 0 anyway.
    if (RR_MODE != 0) begin
      win_idx = rr_hi_found ? rr_hi_idx : rr_lo_idx;
    end else begin
      win_idx = fixed_idx;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    zero_d      = zero_q;
    multi_d     = multi_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      idx_d       = req_zero ? '0 : win_idx;
      zero_d      = req_zero;
      multi_d     = req_multi;
      if (RR_MODE != 0 && !req_zero) begin
        ptr_d = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      zero_q      <= 1'b0;
      multi_q     <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      zero_q      <= zero_d;
      multi_q     <= multi_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign idx       = idx_q;
  assign zero      = zero_q;
  assign multi     = multi_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder: fixed N=8, round-robin N=8 (both
// driven by the same stimulus) and round-robin N=5.
module tb_rr_priority_encoder;

  logic       clk = 1'b0;
  logic       rst;

  // Shared stimulus for the two N=8 instances.
  logic       in_valid8;
  logic [7:0] req8;
  logic       out_ready8;

  logic       f_in_ready, f_out_valid, f_zero, f_multi;
  logic [2:0] f_idx;
  logic       r_in_ready, r_out_valid, r_zero, r_multi;
  logic [2:0] r_idx;

  logic       in_valid5;
  logic [4:0] req5;
  logic       out_ready5;
  logic       p_in_ready, p_out_valid, p_zero, p_multi;
  logic [2:0] p_idx;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  always #5 clk = ~clk;

  rr_priority_encoder #(.N(8), .RR_MODE(0)) u_fix (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(f_in_ready), .req(req8),
    .out_valid(f_out_valid), .out_ready(out_ready8), .idx(f_idx), .zero(f_zero),
    .multi(f_multi)
  );

  rr_priority_encoder #(.N(8), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(r_in_ready), .req(req8),
    .out_valid(r_out_valid), .out_ready(out_ready8), .idx(r_idx), .zero(r_zero),
    .multi(r_multi)
  );

  rr_priority_encoder #(.N(5), .RR_MODE(1)) u_rr5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(p_in_ready), .req(req5),
    .out_valid(p_out_valid), .out_ready(out_ready5), .idx(p_idx), .zero(p_zero),
    .multi(p_multi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] t1_req [9] = '{8'h00, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  int         t1_idx [9] = '{0, 7, 6, 5, 4, 3, 2, 1, 0};

  initial begin
    rst        = 1'b1;
    in_valid8  = 1'b0;
    req8       = '0;
    out_ready8 = 1'b1;
    in_valid5  = 1'b0;
    req5       = '0;
    out_ready5 = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_f_valid", f_out_valid, 0);
    check("rst_f_idx", f_idx, 0);
    check("rst_f_zero", f_zero, 0);
    check("rst_f_multi", f_multi, 0);
    check("rst_f_in_ready", f_in_ready, 1);
    check("rst_r_valid", r_out_valid, 0);
    check("rst_r_ptr", u_rr.ptr_q, 0);

    // 1: fixed mode, back-to-back one-hot sweep
    in_valid8 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req8 = t1_req[i];
      step();
      check($sformatf("t1_valid_%0d", i), f_out_valid, 1);
      check($sformatf("t1_idx_%0d", i), f_idx, t1_idx[i]);
      check($sformatf("t1_zero_%0d", i), f_zero, (i == 0) ? 1 : 0);
      check($sformatf("t1_multi_%0d", i), f_multi, 0);
    end

    // 2: fixed mode, multiple hits
    req8 = 8'h81;
    step();
    check("t2_idx_81", f_idx, 7);
    check("t2_multi_81", f_multi, 1);
    req8 = 8'h06;
    step();
    check("t2_idx_06", f_idx, 2);
    check("t2_multi_06", f_multi, 1);
    check("t2_zero_06", f_zero, 0);
    in_valid8 = 1'b0;
    req8 = 'x;
    step();
    check("drain_valid", f_out_valid, 0);

    // 3: round-robin from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid8 = 1'b1;
    req8 = 8'h81;
    step();
    check("t3_idx_a", r_idx, 0);
    check("t3_multi_a", r_multi, 1);
    check("t3_ptr_a", u_rr.ptr_q, 1);
    step();
    check("t3_idx_b", r_idx, 7);
    check("t3_ptr_b", u_rr.ptr_q, 0);
    step();
    check("t3_idx_c", r_idx, 0);
    check("t3_ptr_c", u_rr.ptr_q, 1);
    req8 = 8'h00;
    step();
    check("t3_zero", r_zero, 1);
    check("t3_zero_idx", r_idx, 0);
    check("t3_zero_ptr", u_rr.ptr_q, 1);

    // 4: backpressure hold
    req8 = 8'h10;
    step();
    check("t4_f_idx", f_idx, 4);
    check("t4_r_idx", r_idx, 4);
    check("t4_r_ptr", u_rr.ptr_q, 5);
    out_ready8 = 1'b0;
    req8 = 8'h02;
    #1;
    check("t4_in_ready_lo", f_in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t4_hold_idx_%0d", i), f_idx, 4);
      check($sformatf("t4_hold_valid_%0d", i), f_out_valid, 1);
      check($sformatf("t4_hold_rdy_%0d", i), f_in_ready, 0);
      check($sformatf("t4_hold_ptr_%0d", i), u_rr.ptr_q, 5);
    end
    out_ready8 = 1'b1;
    #1;
    check("t4_in_ready_hi", f_in_ready, 1);
    step();
    check("t4_f_next_idx", f_idx, 1);
    check("t4_r_next_idx", r_idx, 1);
    check("t4_r_next_ptr", u_rr.ptr_q, 2);

    // 6: reset mid-operation with a held result and ptr=3
    req8 = 8'h04;
    step();
    check("t6_setup_ptr", u_rr.ptr_q, 3);
    out_ready8 = 1'b0;
    req8 = 8'h01;
    step();
    check("t6_setup_valid", r_out_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_valid", r_out_valid, 0);
    check("t6_idx", r_idx, 0);
    check("t6_zero", r_zero, 0);
    check("t6_multi", r_multi, 0);
    check("t6_in_ready", r_in_ready, 1);
    out_ready8 = 1'b1;
    req8 = 8'h88;
    step();
    check("t6_after_idx", r_idx, 3);
    check("t6_after_ptr", u_rr.ptr_q, 4);
    in_valid8 = 1'b0;

    // 5: round-robin N=5, wrap at non-power-of-two
    in_valid5 = 1'b1;
    req5 = 5'b10000;
    step();
    check("t5_idx_a", p_idx, 4);
    check("t5_ptr_a", u_rr5.ptr_q, 0);
    req5 = 5'b10001;
    step();
    check("t5_idx_b", p_idx, 0);
    check("t5_multi_b", p_multi, 1);
    check("t5_ptr_b", u_rr5.ptr_q, 1);
    step();
    check("t5_idx_c", p_idx, 4);
    check("t5_ptr_c", u_rr5.ptr_q, 0);
    req5 = 5'b00001;
    step();
    check("t5_idx_d", p_idx, 0);
    check("t5_ptr_d", u_rr5.ptr_q, 1);
    in_valid5 = 1'b0;
    step();
    check("t5_drain", p_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rr_priority_encoder.md
Name: rr_priority_encoder

Overview:
Parametrised, registered N-to-log2(N) encoder. It is the successor to the combinational 8-to-3 encoder.
- Accepts an N-bit request vector through a valid/ready handshake.
- Produces the binary index of the winning bit one cycle later, plus zero and multi-hit flags.
- Supports two priority modes: fixed MSB-first, or round-robin with a rotating pointer.
- Sits between request sources (interrupt or arbitration lines) and a consumer that may apply backpressure.

Parameters:
N, 8, number of request inputs; legal range 2..256, not required to be a power of two.
W, $clog2(N), index width; derived localparam, not overridden.
RR_MODE, 0, 0 = fixed priority (bit N-1 highest); 1 = round-robin.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  request vector on req is valid.
in_ready  output  1  block can accept req this cycle.
req  input  N  request vector; bit i set = requester i active.
out_valid  output  1  idx, zero and multi hold a valid result.
out_ready  input  1  consumer accepts the result this cycle.
idx  output  W  encoded index of the winning request.
zero  output  1  accepted vector was all zeros.
multi  output  1  accepted vector had more than one bit set.

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - out_valid=0, idx=0, zero=0, multi=0, internal pointer ptr=0.
  - Any held result is discarded. Reset overrides a simultaneous accept.
- in_ready = !out_valid || out_ready. It is combinational from out_ready and has no bubble at full throughput.
- Accept when in_valid && in_ready at a clock edge. On the following cycle:
  - out_valid=1.
  - idx, zero and multi reflect the accepted req.
- Latency is exactly 1 cycle from accept to out_valid.
- Sustained throughput is 1 result per cycle while out_ready=1.
- Output hold: while out_valid=1 and out_ready=0, idx, zero and multi remain stable. Changes on req are ignored.
- Drain: out_valid=1 && out_ready=1 && no new accept leads to out_valid=0 next cycle. idx, zero and multi keep their last values and are don't-care when out_valid=0.
- Simultaneous drain and accept: the new result replaces the old one in the same edge and out_valid stays 1.
- Fixed mode (RR_MODE=0):
  - idx = position of the highest set bit.
  - req=0 gives idx=0, zero=1.
  - ptr is unused and stays 0.
- Round-robin mode (RR_MODE=1):
  - Search starts at ptr, ascends through N-1, then wraps to 0..ptr-1.
  - idx = first set bit found.
  - On accept with req!=0: ptr <= idx+1, with wrap from N-1 to 0 (mod N, valid for non-power-of-two N).
  - req=0 gives idx=0, zero=1, and ptr is unchanged.
  - ptr updates only on accept, never during hold.
- multi = 1 when popcount(req) >= 2, in both modes. zero and multi are mutually exclusive.
- Inputs with in_valid=0 are never sampled. X on req while in_valid=0 must not propagate.
- All outputs are registered except in_ready.

Test Plan:
1. RR_MODE=0, N=8, out_ready=1. Accept req = 00000000, 10000000, 01000000, ..., 00000001 on consecutive cycles. Each result follows one cycle later:
   - 00000000 gives zero=1, idx=0.
   - The one-hot vectors give idx = 7, 6, 5, 4, 3, 2, 1, 0, with zero=0 and multi=0.
2. RR_MODE=0, N=8. req=10000001 gives idx=7, multi=1. req=00000110 gives idx=2, multi=1.
3. RR_MODE=1, N=8, after reset. Accept req=10000001 three times. Expected idx=0, 7, 0, with ptr going 1, 0, 1. Then accept req=00000000: zero=1, ptr stays 1.
4. Backpressure (either mode): accept req=00010000, then hold out_ready=0 for 4 cycles while req changes to 00000010.
   - idx stays 4 and out_valid stays 1 throughout.
   - in_ready=0 while held.
   - Raise out_ready: in_ready=1 in the same cycle, and the next accept takes effect.
5. RR_MODE=1, N=5. Accept req=10000 (idx=4, ptr wraps to 0), then req=10001 gives idx=0. Also check W=3 and that ptr never reaches 5.
6. Reset mid-operation: with out_valid=1, out_ready=0 and ptr=3, assert rst together with in_valid=1.
   - Next cycle: out_valid=0, idx=0, zero=0, multi=0, in_ready=1.
   - The next RR grant searches from 0.
